// File: rtl/lc3_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between LC-3 fetch and data ports.
// One access outstanding at a time; reads return MEM_LAT cycles after the strobe.
module lc3_mem_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instrmem_rd,
  input  logic [15:0] pc,
  output logic [15:0] Instr_dout,
  output logic        complete_instr,
  input  logic        Data_req,
  input  logic        Data_rd,
  input  logic [15:0] Data_addr,
  input  logic [15:0] Data_din,
  output logic [15:0] Data_dout,
  output logic        complete_data,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;  // 1 = data was granted last
  logic        id_q, id_d;                  // 1 = data requester owns the transaction
  logic        wr_q, wr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        complete_instr_q, complete_instr_d;
  logic        complete_data_q, complete_data_d;
  logic [15:0] instr_dout_q, instr_dout_d;
  logic [15:0] data_dout_q, data_dout_d;
  logic        grant_data;

  // Next-state, arbitration and registered-output computation.
  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    id_d             = id_q;
    wr_d             = wr_q;
    cnt_d            = cnt_q;
    mem_en_d         = 1'b0;
    mem_we_d         = 1'b0;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    complete_instr_d = 1'b0;
    complete_data_d  = 1'b0;
    instr_dout_d     = instr_dout_q;
    data_dout_d      = data_dout_q;
    grant_data       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (instrmem_rd || Data_req) begin
          // On a tie the requester not granted last wins.
          grant_data   = Data_req && (!instrmem_rd || !last_grant_q);
          last_grant_d = grant_data;
          id_d         = grant_data;
          wr_d         = grant_data && !Data_rd;
          mem_addr_d   = grant_data ? Data_addr : pc;
          mem_wdata_d  = grant_data ? Data_din : 16'h0000;
          mem_en_d     = 1'b1;
          mem_we_d     = grant_data && !Data_rd;
          state_d      = S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (wr_q) begin
          state_d          = S_RESP;
          complete_instr_d = !id_q;
          complete_data_d  = id_q;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 4'(MEM_LAT);
        end
      end
      S_WAIT: begin
        // Last WAIT cycle is exactly MEM_LAT cycles after the strobe.
        if (cnt_q <= 4'd1) begin
          cnt_d            = 4'd0;
          state_d          = S_RESP;
          complete_instr_d = !id_q;
          complete_data_d  = id_q;
          if (id_q) begin
            data_dout_d = mem_rdata;
          end else begin
            instr_dout_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      last_grant_q     <= 1'b0;
      id_q             <= 1'b0;
      wr_q             <= 1'b0;
      cnt_q            <= 4'd0;
      mem_en_q         <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= 16'h0000;
      mem_wdata_q      <= 16'h0000;
      complete_instr_q <= 1'b0;
      complete_data_q  <= 1'b0;
      instr_dout_q     <= 16'h0000;
      data_dout_q      <= 16'h0000;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      id_q             <= id_d;
      wr_q             <= wr_d;
      cnt_q            <= cnt_d;
      mem_en_q         <= mem_en_d;
      mem_we_q         <= mem_we_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      complete_instr_q <= complete_instr_d;
      complete_data_q  <= complete_data_d;
      instr_dout_q     <= instr_dout_d;
      data_dout_q      <= data_dout_d;
    end
  end

  assign mem_en         = mem_en_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign complete_instr = complete_instr_q;
  assign complete_data  = complete_data_q;
  assign Instr_dout     = instr_dout_q;
  assign Data_dout      = data_dout_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Scoreboard bench for lc3_mem_arbiter: three instances (MEM_LAT 2, 1, 15),
// expected memory strobes and completions queued by stimulus, checked by a monitor.
module tb_lc3_mem_arbiter;
  localparam int NI = 3;

  typedef struct {
    int          inst;
    int          cyc;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wd;
  } acc_t;

  typedef struct {
    int          inst;
    int          cyc;
    logic        isd;
    logic [15:0] dout;
  } cmp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_rd  [NI];
  logic [15:0] pc        [NI];
  logic        data_req  [NI];
  logic        data_rd   [NI];
  logic [15:0] data_addr [NI];
  logic [15:0] data_din  [NI];
  logic [15:0] instr_dout[NI];
  logic [15:0] data_dout [NI];
  logic        c_instr   [NI];
  logic        c_data    [NI];
  logic        mem_en    [NI];
  logic        mem_we    [NI];
  logic [15:0] mem_addr  [NI];
  logic [15:0] mem_wdata [NI];
  logic [15:0] mem_rdata [NI];

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          to_cnt = 0;
  bit          done = 1'b0;
  bit          done_chk = 1'b0;
  int          due [NI] = '{-1, -1, -1};
  logic [15:0] rval[NI];
  acc_t        acc_q[$];
  cmp_t        cmp_q[$];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      lc3_mem_arbiter #(.MEM_LAT((g == 0) ? 2 : ((g == 1) ? 1 : 15))) u_dut (
        .clk           (clk),
        .reset         (reset),
        .instrmem_rd   (instr_rd[g]),
        .pc            (pc[g]),
        .Instr_dout    (instr_dout[g]),
        .complete_instr(c_instr[g]),
        .Data_req      (data_req[g]),
        .Data_rd       (data_rd[g]),
        .Data_addr     (data_addr[g]),
        .Data_din      (data_din[g]),
        .Data_dout     (data_dout[g]),
        .complete_data (c_data[g]),
        .mem_en        (mem_en[g]),
        .mem_we        (mem_we[g]),
        .mem_addr      (mem_addr[g]),
        .mem_wdata     (mem_wdata[g]),
        .mem_rdata     (mem_rdata[g])
      );
    end
  endgenerate

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
  endfunction

  // Memory contents: one fixed word, everything else is the inverted address.
  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return (a == 16'h3000) ? 16'h1234 : ~a;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model (read data valid only in its exact cycle) plus scoreboard monitor.
  always @(posedge clk) begin
    acc_t a;
    cmp_t c;
    #1;
    for (int g = 0; g < NI; g++) begin
      if (cyc == due[g]) mem_rdata[g] <= rval[g];
      else mem_rdata[g] <= 16'hDEAD;
      if (mem_en[g] && !mem_we[g]) begin
        due[g]  <= cyc + lat_of(g);
        rval[g] <= mem_f(mem_addr[g]);
      end

      if (reset) begin
        checks++;
        if (instr_dout[g] != 16'h0 || data_dout[g] != 16'h0 || c_instr[g] || c_data[g] ||
            mem_en[g] || mem_we[g] || mem_addr[g] != 16'h0 || mem_wdata[g] != 16'h0) begin
          errors++;
          $display("FAIL reset_state inst=%0d cyc=%0d got idout=%h ddout=%h ci=%0b cd=%0b en=%0b we=%0b addr=%h wd=%h, expected all zero",
                   g, cyc, instr_dout[g], data_dout[g], c_instr[g], c_data[g], mem_en[g], mem_we[g], mem_addr[g], mem_wdata[g]);
        end
      end

      if (mem_en[g]) begin
        checks++;
        if (acc_q.size() == 0) begin
          errors++;
          $display("FAIL mem_access inst=%0d cyc=%0d got unexpected strobe addr=%h we=%0b, expected none", g, cyc, mem_addr[g], mem_we[g]);
        end else begin
          a = acc_q.pop_front();
          if (a.inst != g || a.cyc != cyc || a.we != mem_we[g] || a.addr != mem_addr[g] ||
              (a.we && a.wd != mem_wdata[g])) begin
            errors++;
            $display("FAIL mem_access inst=%0d got cyc=%0d we=%0b addr=%h wd=%h, expected inst=%0d cyc=%0d we=%0b addr=%h wd=%h",
                     g, cyc, mem_we[g], mem_addr[g], mem_wdata[g], a.inst, a.cyc, a.we, a.addr, a.wd);
          end
        end
      end

      if (c_instr[g] || c_data[g]) begin
        checks++;
        if (cmp_q.size() == 0) begin
          errors++;
          $display("FAIL completion inst=%0d cyc=%0d got unexpected ci=%0b cd=%0b, expected none", g, cyc, c_instr[g], c_data[g]);
        end else begin
          c = cmp_q.pop_front();
          if (c.inst != g || c.cyc != cyc || (c_instr[g] && c_data[g]) || c.isd != c_data[g] ||
              c.dout != (c.isd ? data_dout[g] : instr_dout[g])) begin
            errors++;
            $display("FAIL completion inst=%0d got cyc=%0d ci=%0b cd=%0b idout=%h ddout=%h, expected inst=%0d cyc=%0d data=%0b dout=%h",
                     g, cyc, c_instr[g], c_data[g], instr_dout[g], data_dout[g], c.inst, c.cyc, c.isd, c.dout);
          end
        end
      end
    end

    if (done && !done_chk) begin
      done_chk = 1'b1;
      checks++;
      if (acc_q.size() != 0 || cmp_q.size() != 0 || to_cnt != 0) begin
        errors++;
        $display("FAIL drain got pending_acc=%0d pending_cmp=%0d timeouts=%0d, expected 0 0 0", acc_q.size(), cmp_q.size(), to_cnt);
      end
    end
  end

  task automatic push(input int inst, input logic we, input logic [15:0] addr, input logic [15:0] wd,
                      input logic isd, input logic [15:0] dout, input int t_acc, input int t_cmp);
    acc_t a;
    cmp_t c;
    a = '{inst: inst, cyc: t_acc, we: we, addr: addr, wd: wd};
    c = '{inst: inst, cyc: t_cmp, isd: isd, dout: dout};
    acc_q.push_back(a);
    cmp_q.push_back(c);
  endtask

  // Act as the requesters: drop each request on its completion (unless held).
  task automatic serve(input int inst, input int n, input bit hold);
    int seen = 0;
    int k = 0;
    while (seen < n && k < 400) begin
      @(negedge clk);
      k++;
      if (c_instr[inst]) begin
        seen++;
        if (!hold) instr_rd[inst] = 1'b0;
      end
      if (c_data[inst]) begin
        seen++;
        if (!hold) data_req[inst] = 1'b0;
      end
    end
    instr_rd[inst] = 1'b0;
    data_req[inst] = 1'b0;
    if (seen < n) begin
      to_cnt++;
      $display("FAIL serve_timeout inst=%0d got %0d completions, expected %0d", inst, seen, n);
    end
  endtask

  initial begin
    int t0;
    reset = 1'b1;
    for (int g = 0; g < NI; g++) begin
      instr_rd[g]  = 1'b0;
      pc[g]        = 16'h0;
      data_req[g]  = 1'b0;
      data_rd[g]   = 1'b0;
      data_addr[g] = 16'h0;
      data_din[g]  = 16'h0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Fetch from 3000
    t0 = cyc;
    pc[0] = 16'h3000; instr_rd[0] = 1'b1;
    push(0, 1'b0, 16'h3000, 16'h0, 1'b0, 16'h1234, t0 + 1, t0 + 4);
    serve(0, 1, 1'b0);
    @(negedge clk);

    // Data read from 5000
    t0 = cyc;
    data_addr[0] = 16'h5000; data_rd[0] = 1'b1; data_req[0] = 1'b1;
    push(0, 1'b0, 16'h5000, 16'h0, 1'b1, 16'hAFFF, t0 + 1, t0 + 4);
    serve(0, 1, 1'b0);
    @(negedge clk);

    // Data read dropped right after grant still completes
    t0 = cyc;
    data_addr[0] = 16'h5002; data_rd[0] = 1'b1; data_req[0] = 1'b1;
    push(0, 1'b0, 16'h5002, 16'h0, 1'b1, 16'hAFFD, t0 + 1, t0 + 4);
    @(negedge clk);
    data_req[0] = 1'b0; data_addr[0] = 16'h1111;
    serve(0, 1, 1'b0);
    @(negedge clk);

    // Write leaves Data_dout untouched
    t0 = cyc;
    data_addr[0] = 16'h4000; data_din[0] = 16'hBEEF; data_rd[0] = 1'b0; data_req[0] = 1'b1;
    push(0, 1'b1, 16'h4000, 16'hBEEF, 1'b1, 16'hAFFD, t0 + 1, t0 + 2);
    serve(0, 1, 1'b0);
    @(negedge clk);

    // Reset, then both held: data wins first, then strict alternation
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    t0 = cyc;
    pc[0] = 16'h3002; instr_rd[0] = 1'b1;
    data_addr[0] = 16'h6000; data_rd[0] = 1'b1; data_req[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) push(0, 1'b0, 16'h6000, 16'h0, 1'b1, 16'h9FFF, t0 + 1 + 5 * k, t0 + 4 + 5 * k);
      else push(0, 1'b0, 16'h3002, 16'h0, 1'b0, 16'hCFFD, t0 + 1 + 5 * k, t0 + 4 + 5 * k);
    end
    serve(0, 6, 1'b1);
    @(negedge clk);

    // Reset in the middle of a fetch aborts it
    t0 = cyc;
    pc[0] = 16'h3004; instr_rd[0] = 1'b1;
    acc_q.push_back('{inst: 0, cyc: t0 + 1, we: 1'b0, addr: 16'h3004, wd: 16'h0});
    repeat (2) @(negedge clk);
    reset = 1'b1; instr_rd[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    t0 = cyc;
    pc[0] = 16'h3006; instr_rd[0] = 1'b1;
    push(0, 1'b0, 16'h3006, 16'h0, 1'b0, 16'hCFF9, t0 + 1, t0 + 4);
    serve(0, 1, 1'b0);
    @(negedge clk);

    // Latency extremes
    t0 = cyc;
    data_addr[1] = 16'h7000; data_rd[1] = 1'b1; data_req[1] = 1'b1;
    push(1, 1'b0, 16'h7000, 16'h0, 1'b1, 16'h8FFF, t0 + 1, t0 + 3);
    serve(1, 1, 1'b0);
    @(negedge clk);
    t0 = cyc;
    pc[2] = 16'h3000; instr_rd[2] = 1'b1;
    push(2, 1'b0, 16'h3000, 16'h0, 1'b0, 16'h1234, t0 + 1, t0 + 17);
    serve(2, 1, 1'b0);

    repeat (3) @(negedge clk);
    done = 1'b1;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
